// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC generation, single-outstanding imem request, 2-entry fetch buffer.
// Optional FETCH_BYPASS_EN: present a response combinationally when the buffer is empty.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0] r_out_pc, w_out_pc_nxt;
    logic        r_outstanding, w_outstanding_nxt;
    logic        r_drop, w_drop_nxt;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_inst [2];
    logic        r_rd_ptr, r_wr_ptr;
    logic [1:0]  r_count, w_count_nxt;

    logic w_gnt, w_resp, w_keep, w_bypass, w_buf_valid;
    logic w_pop, w_pop_buf, w_push, w_still_out;

    // Memory handshake: a request transfers in any cycle with imem_req_o=1 and imem_gnt_i=1;
    // imem_addr_o holds until then. The single response is the next cycle with imem_rvalid_i=1.
    // IF/ID side: an instruction transfers when if_valid_o=1 and stall_i=0 (no redirect).
    assign imem_req_o  = rst & (r_state == S_REQ);
    assign imem_addr_o = r_fetch_pc;
    assign dbg_state_o = r_state;

    assign w_gnt       = imem_req_o & imem_gnt_i;
    assign w_resp      = imem_rvalid_i & r_outstanding;
    assign w_keep      = w_resp & ~r_drop & ~branch_flag_i;
    assign w_buf_valid = (r_count != 2'd0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_keep & ~w_buf_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign if_valid_o = w_buf_valid | w_bypass;
    assign if_pc_o    = w_buf_valid ? r_buf_pc[r_rd_ptr]   : (w_bypass ? r_out_pc     : 32'h0);
    assign if_inst_o  = w_buf_valid ? r_buf_inst[r_rd_ptr] : (w_bypass ? imem_rdata_i : 32'h0);

    assign w_pop       = if_valid_o & ~stall_i & ~branch_flag_i;
    assign w_pop_buf   = w_pop & w_buf_valid;
    // A bypassed response that is consumed immediately never enters the buffer.
    assign w_push      = w_keep & ~(w_bypass & w_pop);
    assign w_still_out = (r_outstanding & ~imem_rvalid_i) | w_gnt;
    assign w_count_nxt = branch_flag_i ? 2'd0
                       : (r_count + {1'b0, w_push} - {1'b0, w_pop_buf});

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_out_pc_nxt      = r_out_pc;
        w_outstanding_nxt = r_outstanding;
        w_drop_nxt        = r_drop;
        if (branch_flag_i) begin
            w_fetch_pc_nxt = branch_target_i;
            if (w_gnt) begin
                w_out_pc_nxt = r_fetch_pc;
            end
            if (w_still_out) begin
                w_state_nxt       = S_WAIT;
                w_outstanding_nxt = 1'b1;
                w_drop_nxt        = 1'b1;
            end else begin
                w_state_nxt       = S_REQ;
                w_outstanding_nxt = 1'b0;
                w_drop_nxt        = 1'b0;
            end
        end else begin
            if (w_resp) begin
                w_outstanding_nxt = 1'b0;
                w_drop_nxt        = 1'b0;
            end
            case (r_state)
                S_REQ: begin
                    if (w_gnt) begin
                        w_fetch_pc_nxt    = r_fetch_pc + 32'd4;
                        w_out_pc_nxt      = r_fetch_pc;
                        w_outstanding_nxt = 1'b1;
                        w_state_nxt       = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_resp) begin
                        w_state_nxt = (w_count_nxt < FULL_CNT) ? S_REQ : S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_count_nxt < FULL_CNT) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_REQ;
            r_fetch_pc    <= RESET_PC;
            r_out_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_count       <= 2'd0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_out_pc      <= w_out_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
            r_count       <= w_count_nxt;
            if (branch_flag_i) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop_buf) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    // Buffer payload needs no reset: it is only observed through r_count.
    always_ff @(posedge clk) begin
        if (w_push && !branch_flag_i) begin
            r_buf_pc[r_wr_ptr]   <= r_out_pc;
            r_buf_inst[r_wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table, reset/latency sequence, randomized run vs. a program-order model.
module tb_inst_fetch;

    localparam logic [31:0] RP   = 32'h0000_1000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, branch_flag_i, imem_gnt_i, imem_rvalid_i;
    logic [31:0] branch_target_i, imem_rdata_i;
    logic        imem_req_o, if_valid_o;
    logic [31:0] imem_addr_o, if_pc_o, if_inst_o;
    logic [1:0]  dbg_state_o;

    inst_fetch #(.RESET_PC(RP), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic g, input logic rv, input logic [31:0] rd);
        stall_i         = st;
        branch_flag_i   = br;
        branch_target_i = tgt;
        imem_gnt_i      = g;
        imem_rvalid_i   = rv;
        imem_rdata_i    = rd;
    endtask

    // Behavioural memory: grants with probability gnt_pct, answers 1..lat_max+1 cycles later.
    int          gnt_pct = 70;
    int          lat_max = 2;
    logic        pend_v  = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;

    task automatic mem_step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (pend_v) begin
            if (pend_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(pend_addr);
                pend_v        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (imem_req_o && ($urandom_range(0, 99) < gnt_pct)) begin
            imem_gnt_i = 1'b1;
            pend_v     = 1'b1;
            pend_addr  = imem_addr_o;
            pend_cnt   = $urandom_range(0, lat_max);
        end
    endtask

    // Program-order model: granted addresses in order, flushed on redirect.
    task automatic monitor();
        if (imem_req_o && imem_gnt_i) begin
            chk("req_addr", imem_addr_o, exp_req);
            exp_q.push_back(exp_req);
            chk("occupancy_le2", 32'(exp_q.size() <= 2), 32'd1);
            exp_req = exp_req + 32'd4;
        end
        if (!if_valid_o) chk("nop_when_invalid", if_inst_o, 32'h0);
        if (if_valid_o && !stall_i && !branch_flag_i) begin
            chk("pop_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("pop_pc", if_pc_o, exp_q[0]);
                chk("pop_inst", if_inst_o, mem_word(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (branch_flag_i) begin
            exp_q.delete();
            exp_req = branch_target_i;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        stall, br;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic st, input logic br, input logic [31:0] tgt,
                       input logic g, input logic rv, input logic [31:0] rd,
                       input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = st; v.br = br; v.tgt = tgt; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev;
        v.e_pc   = ev ? ep : 32'h0;
        v.e_inst = ev ? mem_word(ep) : 32'h0;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        // stall br tgt | gnt rv rdata | req addr valid pc
        row(0, 0, 0,            1, 0, 0,                    1, RP,           0, 0);
        row(0, 0, 0,            0, 1, mem_word(RP),         0, RP + 4,       0, 0);
        row(0, 0, 0,            1, 0, 0,                    1, RP + 4,       1, RP);
        row(0, 0, 0,            0, 1, mem_word(RP + 4),     0, RP + 8,       0, 0);
        row(0, 0, 0,            1, 0, 0,                    1, RP + 8,       1, RP + 4);
        row(0, 0, 0,            0, 1, mem_word(RP + 8),     0, RP + 12,      0, 0);
        row(1, 0, 0,            0, 0, 0,                    1, RP + 12,      1, RP + 8);
        row(1, 0, 0,            1, 0, 0,                    1, RP + 12,      1, RP + 8);
        row(1, 0, 0,            0, 1, mem_word(RP + 12),    0, RP + 16,      1, RP + 8);
        row(1, 0, 0,            1, 0, 0,                    0, RP + 16,      1, RP + 8);
        row(0, 0, 0,            0, 0, 0,                    0, RP + 16,      1, RP + 8);
        row(0, 0, 0,            0, 0, 0,                    1, RP + 16,      1, RP + 12);
        row(0, 0, 0,            1, 0, 0,                    1, RP + 16,      0, 0);
        row(0, 1, 32'h100,      0, 0, 0,                    0, RP + 20,      0, 0);
        row(0, 0, 0,            0, 1, JUNK,                 0, 32'h100,      0, 0);
        row(0, 0, 0,            1, 0, 0,                    1, 32'h100,      0, 0);
        row(0, 0, 0,            0, 1, mem_word(32'h100),    0, 32'h104,      0, 0);
        row(1, 0, 0,            0, 0, 0,                    1, 32'h104,      1, 32'h100);
        row(1, 0, 0,            1, 0, 0,                    1, 32'h104,      1, 32'h100);
        row(1, 1, 32'h200,      0, 1, mem_word(32'h104),    0, 32'h108,      1, 32'h100);
        row(0, 0, 0,            0, 0, 0,                    1, 32'h200,      0, 0);
        row(0, 0, 0,            1, 0, 0,                    1, 32'h200,      0, 0);
        row(0, 0, 0,            0, 1, mem_word(32'h200),    0, 32'h204,      0, 0);
        row(0, 0, 0,            0, 0, 0,                    1, 32'h204,      1, 32'h200);
        row(0, 1, 32'h302,      0, 0, 0,                    1, 32'h204,      0, 0);
        row(0, 0, 0,            0, 0, 0,                    1, 32'h302,      0, 0);
        row(0, 1, 32'hFFFF_FFFC, 1, 0, 0,                   1, 32'h302,      0, 0);
        row(0, 0, 0,            0, 1, JUNK,                 0, 32'hFFFF_FFFC, 0, 0);
        row(0, 0, 0,            1, 0, 0,                    1, 32'hFFFF_FFFC, 0, 0);
        row(0, 0, 0,            0, 1, mem_word(32'hFFFF_FFFC), 0, 32'h0,     0, 0);
        row(0, 0, 0,            0, 0, 0,                    1, 32'h0,        1, 32'hFFFF_FFFC);
        row(0, 0, 0,            0, 0, 0,                    1, 32'h0,        0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, RP);
        chk("rst_valid", 32'(if_valid_o), 32'd0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_inst", if_inst_o, 32'h0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) next_cycle();
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("row%0d_req", i), 32'(imem_req_o), 32'(vecs[i].e_req));
            chk($sformatf("row%0d_addr", i), imem_addr_o, vecs[i].e_addr);
`ifndef FETCH_BYPASS_EN
            chk($sformatf("row%0d_valid", i), 32'(if_valid_o), 32'(vecs[i].e_valid));
            chk($sformatf("row%0d_pc", i), if_pc_o, vecs[i].e_pc);
            chk($sformatf("row%0d_inst", i), if_inst_o, vecs[i].e_inst);
`endif
        end

        // Reset in WAIT; the stale response after release must be ignored.
        next_cycle();
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("seqrst_grant_req", 32'(imem_req_o), 32'd1);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("seqrst_req", 32'(imem_req_o), 32'd0);
        chk("seqrst_addr", imem_addr_o, RP);
        chk("seqrst_valid", 32'(if_valid_o), 32'd0);
        chk("seqrst_pc", if_pc_o, 32'h0);
        next_cycle();
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, JUNK);
        @(negedge clk);
        chk("stale_req", 32'(imem_req_o), 32'd1);
        chk("stale_addr", imem_addr_o, RP);
        chk("stale_valid", 32'(if_valid_o), 32'd0);
        chk("stale_inst", if_inst_o, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stale_after_valid", 32'(if_valid_o), 32'd0);
        chk("stale_after_req", 32'(imem_req_o), 32'd1);
        next_cycle();
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("lat_grant_addr", imem_addr_o, RP);
        next_cycle();
        drive(0, 0, 0, 0, 1, mem_word(RP));
        @(negedge clk);
        chk("lat_rv_valid", 32'(if_valid_o), 32'(BYP));
        chk("lat_rv_pc", if_pc_o, BYP ? RP : 32'h0);
        chk("lat_rv_inst", if_inst_o, BYP ? mem_word(RP) : 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lat_next_valid", 32'(if_valid_o), 32'(!BYP));
        chk("lat_next_pc", if_pc_o, BYP ? 32'h0 : RP);

        // Randomized run against the program-order model.
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b1;
        exp_q.delete();
        exp_req = RP;
        pend_v  = 1'b0;
        #0;
        for (int i = 0; i < 3000; i++) begin
            if (i != 0) next_cycle();
            if (i >= 995 && i < 1012) begin
                gnt_pct = 100;
                lat_max = 0;
            end else begin
                gnt_pct = 70;
                lat_max = 2;
            end
            mem_step();
            stall_i         = ($urandom_range(0, 99) < 30);
            branch_flag_i   = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 3))
                0:       branch_target_i = $urandom & 32'hFFFF_FFFC;
                1:       branch_target_i = $urandom;
                2:       branch_target_i = 32'hFFFF_FFF8;
                default: branch_target_i = RP;
            endcase
            if (i >= 995 && i < 1012) branch_flag_i = 1'b0;
            if (i >= 1000 && i < 1010) stall_i = 1'b1;
            if (i >= 1010 && i < 1012) stall_i = 1'b0;
            @(negedge clk);
            monitor();
            if (i >= 1007 && i < 1010) begin
                chk("stall_full_req", 32'(imem_req_o), 32'd0);
                chk("stall_full_valid", 32'(if_valid_o), 32'd1);
            end
            if (i >= 1010 && i < 1012) chk("release_pop_valid", 32'(if_valid_o), 32'd1);
            if (i == 1011) chk("release_resume_req", 32'(imem_req_o), 32'd1);
        end

        // Drain: stop granting and let every granted fetch come out.
        gnt_pct = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            mem_step();
            stall_i       = 1'b0;
            branch_flag_i = 1'b0;
            @(negedge clk);
            monitor();
            if (exp_q.size() == 0) break;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the MIPS pipeline. Generates the program counter and fetches instructions from instruction memory over a request/grant/response handshake. Buffers up to two fetched instructions and presents them, with their PCs, to the IF/ID pipeline register. Handles stalls from pipeline control and branch/jump redirects from decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: fetch-buffer entries. Only the value 2 is supported.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low. 0 = reset asserted.
- `stall_i` in 1: pipeline control hold; 1 = IF/ID does not accept this cycle.
- `branch_flag_i` in 1: redirect request from decode, one-cycle pulse.
- `branch_target_i` in 32: redirect address, valid with `branch_flag_i`.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address; stable while `imem_req_o`=1 and no grant.
- `imem_gnt_i` in 1: memory accepted the request this cycle.
- `imem_rvalid_i` in 1: response data valid; earliest one cycle after grant.
- `imem_rdata_i` in 32: instruction word.
- `if_valid_o` out 1: `if_pc_o`/`if_inst_o` hold a real instruction.
- `if_pc_o` out 32: PC of the presented instruction.
- `if_inst_o` out 32: presented instruction; 32'h0 (nop) when `if_valid_o`=0.

## Operation
- Internal state:
  - `fetch_pc`: next address to request.
  - `outstanding`: 0 or 1.
  - `drop`: discard the next response.
  - Two-entry FIFO of {pc, inst}, with `count` 0..2.
- FSM states:
  - REQ: `imem_req_o`=1, `imem_addr_o`=`fetch_pc`. On `imem_gnt_i`: `fetch_pc` += 4 (mod 2^32), `outstanding`=1, go to WAIT.
  - WAIT: `imem_req_o`=0. On `imem_rvalid_i`: push {addr, rdata} unless `drop` (if dropped, clear `drop`), `outstanding`=0. Then go to REQ if post-update `count` < 2, else FULL.
  - FULL: `imem_req_o`=0. Go to REQ when a pop makes `count` < 2.
- Request rule: a request is issued only when `count` + `outstanding` < 2. The FIFO therefore never overflows and needs no push-when-full handling.
- Pop: occurs when `if_valid_o`=1 and `stall_i`=0. The head is presented on the outputs.
- Simultaneous push and pop: both occur; `count` is unchanged.
- Redirect (`branch_flag_i`=1), which has priority over everything else:
  - Flush the FIFO (`count`=0) and set `fetch_pc`=`branch_target_i`.
  - If `outstanding`=1, or a grant arrives in the same cycle, set `drop`=1 and go to WAIT. Otherwise go to REQ.
  - A response arriving in the redirect cycle is discarded.
  - The redirect wins over `stall_i` and over a pop in the same cycle.
- Redirect during REQ without grant: `imem_addr_o` changes to the target on the next cycle. Instruction memory tolerates an address change before grant.
- No alignment checking of `branch_target_i`; the low two bits pass through.

## Timing
- Reset values:
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0.
  - `count`=0, `outstanding`=0, `drop`=0, state REQ.
- First `imem_req_o`=1 is in the first cycle after `rst` deasserts.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). Any in-flight response is ignored.
- Fetch latency, non-bypass build: rvalid in cycle N gives `if_valid_o`=1 in cycle N+1.
- Throughput: one instruction per (grant-to-rvalid + 1) cycles. Only one request is ever outstanding.
- Outputs are registered; there are no combinational paths from inputs to `if_*` outputs, except under the bypass feature.
- `imem_req_o` and `imem_addr_o` depend only on registered state.

## Configuration
- `FETCH_BYPASS_EN`:
  - Defined: when `count`=0 and a non-dropped response arrives, the response drives `if_valid_o`/`if_pc_o`/`if_inst_o` combinationally in the same cycle.
    - If popped that cycle (`stall_i`=0, no redirect), it is not pushed.
    - Otherwise it is pushed as normal.
    - Latency is rvalid in N gives `if_valid_o`=1 in N.
  - Undefined: fully registered outputs, with latency as in Timing.

## Test plan
- Reset release, memory grants immediately, rvalid 1 cycle later, `stall_i`=0 → requests to 0x0, 0x4, 0x8 in turn; `if_pc_o` sequence 0x0, 0x4, 0x8 with matching instructions; `if_inst_o`=0 whenever `if_valid_o`=0.
- `stall_i`=1 held for 10 cycles → exactly two responses buffered; `imem_req_o` stays 0 in FULL. On release, the two instructions pop in order on consecutive cycles, then fetching resumes.
- Redirect to 0x100 while a response is outstanding → that response is dropped, FIFO flushed, next request address 0x100, next `if_pc_o` 0x100.
- `branch_flag_i` together with `imem_rvalid_i` and `stall_i`=1 in the same cycle → the response is discarded, the FIFO is empty, and the next request is to the target.
- `fetch_pc`=0xFFFF_FFFC granted → next request address 0x0000_0000 (wrap-around).
- `rst` asserted in WAIT, with rvalid arriving after release → `if_valid_o` stays 0 for the stale data; the first request after release goes to `RESET_PC`. Also check bypass-build latency (valid in the rvalid cycle).
